// File: rtl/dmem_pkg.sv
// Shared types and size helpers for the data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Wide enough for the largest supported wait-state count (15).
  localparam int CNT_W = 4;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int offs_w_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_w_of(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous byte-enabled RAM, DEPTH words of DATA_W bits.
// The read register only changes on an enabled read, so it holds its value otherwise.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic                         we,
  input  logic [bytes_of(DATA_W)-1:0]  be,
  input  logic [idx_w_of(DEPTH)-1:0]   idx,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-masked write or registered read of one word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < bytes_of(DATA_W); b++) begin
          if (be[b]) begin
            mem[idx][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: req/ready/rvalid handshake, WAIT_STATES extra
// cycles per access, byte strobes and a relocatable base address.
// Optional feature macro DMEM_CHECK_EN: flags misaligned and out-of-range
// accesses with o_err and suppresses their effect. Without it, offset
// bits are ignored and the word index aliases modulo DEPTH.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 1024,
  parameter int                WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [DATA_W/8-1:0]  i_be,
  output logic                 o_ready,
  output logic                 o_rvalid,
  output logic [DATA_W-1:0]    o_rdata,
  output logic                 o_err
);

  localparam int BYTES  = bytes_of(DATA_W);
  localparam int OFFS_W = offs_w_of(DATA_W);
  localparam int IDX_W  = idx_w_of(DEPTH);
  localparam logic [CNT_W-1:0] WLAST = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               accept, enter_resp;

  logic [ADDR_W-1:0]  diff, idx_full;
  logic [IDX_W-1:0]   idx_in;
  logic               err_in;

  logic               we_q, err_q;
  logic [BYTES-1:0]   be_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [IDX_W-1:0]   idx_q;

  logic               use_live;
  logic               arr_en, arr_we;
  logic [BYTES-1:0]   arr_be;
  logic [IDX_W-1:0]   arr_idx;
  logic [DATA_W-1:0]  arr_wdata, arr_rdata;
  logic [DATA_W-1:0]  rdata_q;

  assign diff     = i_addr - BASE_ADDR;
  assign idx_full = diff >> OFFS_W;
  assign idx_in   = idx_full[IDX_W-1:0];

`ifdef DMEM_CHECK_EN
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
  assign err_in = (|(i_addr & OFF_MASK)) | (|idx_full[ADDR_W-1:IDX_W]);
`else
  logic unused_idx_hi;
  assign unused_idx_hi = ^idx_full[ADDR_W-1:IDX_W];
  assign err_in        = 1'b0;
`endif

  assign accept = i_req & (state == IDLE) & ~i_reset;

  // Next-state, wait counter and the "array access this edge" strobe.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt = '0;
          if (WAIT_STATES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == WLAST) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and wait counter; reset abandons any pending access.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request latch, captured at accept so the requester may move on.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      we_q    <= i_we;
      err_q   <= err_in;
      be_q    <= i_be;
      wdata_q <= i_wdata;
      idx_q   <= idx_in;
    end
  end

  // With zero wait states the array is accessed on the accept edge itself,
  // before the latch holds the request, so the live inputs are used then.
  assign use_live  = (state == IDLE);
  assign arr_we    = use_live ? i_we    : we_q;
  assign arr_be    = use_live ? i_be    : be_q;
  assign arr_idx   = use_live ? idx_in  : idx_q;
  assign arr_wdata = use_live ? i_wdata : wdata_q;
  assign arr_en    = enter_resp & ~(use_live ? err_in : err_q);

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (i_clk),
    .en    (arr_en),
    .we    (arr_we),
    .be    (arr_be),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign o_ready  = (state == IDLE);
  assign o_rvalid = (state == RESP);
  assign o_err    = (state == RESP) & err_q;

  // Read data is presented during a read response, otherwise the last shown value.
  assign o_rdata = ((state == RESP) && !we_q) ? (err_q ? '0 : arr_rdata) : rdata_q;

  // Holds the last presented read data across writes and idle cycles.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= o_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: a zero-wait-state instance driven from a vector
// table, and a three-wait-state instance with a relocated base address
// for the multi-cycle and reset corner cases. Expectations track
// DMEM_CHECK_EN so the bench matches either build.
module tb_dmem_ctrl;

`ifdef DMEM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int W3 = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, req0, we0, rdy0, rv0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  be0;
  logic        rst3, req3, we3, rdy3, rv3, err3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [3:0]  be3;

  resp_t q0[$];
  resp_t q3[$];
  vec_t  tbl[13];
  int    checks = 0;
  int    fails  = 0;

  dmem_ctrl #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)
  ) u0 (
    .i_clk(clk), .i_reset(rst0), .i_req(req0), .i_we(we0), .i_addr(addr0),
    .i_wdata(wdata0), .i_be(be0), .o_ready(rdy0), .o_rvalid(rv0),
    .o_rdata(rdata0), .o_err(err0)
  );

  dmem_ctrl #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(W3), .BASE_ADDR(32'h1000)
  ) u3 (
    .i_clk(clk), .i_reset(rst3), .i_req(req3), .i_we(we3), .i_addr(addr3),
    .i_wdata(wdata3), .i_be(be3), .o_ready(rdy3), .o_rvalid(rv3),
    .o_rdata(rdata3), .o_err(err3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Response monitors: every rvalid must match the oldest expected response.
  always @(negedge clk) begin : mon0
    resp_t e;
    if (rv0) begin
      chk("u0_resp_expected", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("u0_rdata", rdata0, e.rdata);
        chk("u0_err", 32'(err0), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin : mon3
    resp_t e;
    if (rv3) begin
      chk("u3_resp_expected", 32'(q3.size() > 0), 32'd1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        chk("u3_rdata", rdata3, e.rdata);
        chk("u3_err", 32'(err3), 32'(e.err));
      end
    end
  end

  task automatic start0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
    int n;
    n = 0;
    @(negedge clk);
    req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; be0 = be;
    while (!rdy0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("u0_accept_in_time", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1 req0 = 1'b0;
  endtask

  task automatic start3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
    int n;
    n = 0;
    @(negedge clk);
    req3 = 1'b1; we3 = we; addr3 = addr; wdata3 = wdata; be3 = be;
    while (!rdy3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("u3_accept_in_time", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1 req3 = 1'b0;
  endtask

  task automatic run0(input vec_t v, input string tag);
    resp_t e;
    int n;
    e.rdata = v.rdata;
    e.err   = v.err;
    q0.push_back(e);
    start0(v.we, v.addr, v.wdata, v.be);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rv0 && n < 20);
    chk({tag, "_latency"}, 32'(n), 32'd1);
    @(negedge clk);
    chk({tag, "_rvalid_one_cycle"}, 32'(rv0), 32'd0);
  endtask

  task automatic run3(input vec_t v, input string tag);
    resp_t e;
    int n;
    e.rdata = v.rdata;
    e.err   = v.err;
    q3.push_back(e);
    start3(v.we, v.addr, v.wdata, v.be);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rv3 && n < 20);
    chk({tag, "_latency"}, 32'(n), 32'(W3 + 1));
    @(negedge clk);
    chk({tag, "_rvalid_one_cycle"}, 32'(rv3), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
    rst3 = 1'b1; req3 = 1'b0; we3 = 1'b0; addr3 = '0; wdata3 = '0; be3 = '0;

    tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0};
    tbl[4]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[5]  = '{1'b1, 32'h20,   32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 1'b0};
    tbl[6]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[7]  = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h11BB33DD, 1'b0};
    tbl[8]  = '{1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h11BB33DD, CHK};
    tbl[9]  = '{1'b0, 32'h0,    32'h0,        4'h0, (CHK ? 32'hCAFEF00D : 32'h12345678), 1'b0};
    tbl[10] = '{1'b0, 32'h2,    32'h0,        4'h0, (CHK ? 32'h0 : 32'h12345678), CHK};
    tbl[11] = '{1'b1, 32'hFFC,  32'h0BADC0DE, 4'hF, (CHK ? 32'h0 : 32'h12345678), 1'b0};
    tbl[12] = '{1'b0, 32'hFFC,  32'h0,        4'h0, 32'h0BADC0DE, 1'b0};

    @(negedge clk);
    chk("rst_u0_ready",  32'(rdy0), 32'd1);
    chk("rst_u0_rvalid", 32'(rv0),  32'd0);
    chk("rst_u0_rdata",  rdata0,    32'h0);
    chk("rst_u0_err",    32'(err0), 32'd0);
    chk("rst_u3_ready",  32'(rdy3), 32'd1);
    chk("rst_u3_rvalid", 32'(rv3),  32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    rst3 = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run0(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset during the response cycle of a write: outputs clear at once,
    // the committed write survives.
    start0(1'b1, 32'h40, 32'h600DF00D, 4'hF);
    #1 rst0 = 1'b1;
    #1;
    chk("rst_resp_ready",  32'(rdy0), 32'd1);
    chk("rst_resp_rvalid", 32'(rv0),  32'd0);
    chk("rst_resp_rdata",  rdata0,    32'h0);
    chk("rst_resp_err",    32'(err0), 32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    run0('{1'b0, 32'h40, 32'h0, 4'h0, 32'h600DF00D, 1'b0}, "rd_after_resp_rst");

    // Wait-state instance: seed a word through the relocated base.
    run3('{1'b1, 32'h1030, 32'h11111111, 4'hF, 32'h0, 1'b0}, "u3_wr");

    // Read with the request held (as a different write) while busy.
    begin
      resp_t e;
      e.rdata = 32'h11111111;
      e.err   = 1'b0;
      q3.push_back(e);
    end
    start3(1'b0, 32'h1030, 32'h0, 4'h0);
    req3 = 1'b1; we3 = 1'b1; wdata3 = 32'hFFFFFFFF; be3 = 4'hF;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("u3_ready_c%0d", k),  32'(rdy3), 32'(k == 5));
      chk($sformatf("u3_rvalid_c%0d", k), 32'(rv3),  32'(k == 4));
      if (k == 5) req3 = 1'b0;
    end

    // Reset while a write is waiting: the write must never land.
    start3(1'b1, 32'h1030, 32'h00000055, 4'hF);
    #2 rst3 = 1'b1;
    @(negedge clk);
    chk("u3_rst_wait_ready",  32'(rdy3), 32'd1);
    chk("u3_rst_wait_rvalid", 32'(rv3),  32'd0);
    @(posedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    run3('{1'b0, 32'h1030, 32'h0, 4'h0, 32'h11111111, 1'b0}, "u3_rd_after_rst");

    repeat (3) @(negedge clk);
    chk("u0_queue_drained", 32'(q0.size()), 32'd0);
    chk("u3_queue_drained", 32'(q3.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
